// File: rtl/pipo_rr_load_sequencer.sv
// Round-robin arbiter that shares one PIPO register among NUM_REQ requesters.
// Each grant runs one load cycle, HOLD_CYCLES quiet cycles, then a done pulse.
module pipo_rr_load_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          load,
    output logic [DATA_WIDTH-1:0]         parallel_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          done
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t          state;
    logic [CW-1:0]   hold_cnt;
    logic [IDW-1:0]  last;
    logic            found;
    logic [IDW-1:0]  sel;
    logic [DATA_WIDTH-1:0] sel_data;

    // First valid requester after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        sel      = last;
        sel_data = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] && ((int'(last) + k) % NUM_REQ) == i) begin
                    found = 1'b1;
                    sel   = IDW'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IDW'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            load        <= 1'b0;
            parallel_in <= '0;
            req_ready   <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hold_cnt    <= '0;
            last        <= IDW'(NUM_REQ - 1);
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && found) begin
                        grant_id    <= sel;
                        parallel_in <= sel_data;
                        last        <= sel;
                        load        <= 1'b1;
                        req_ready   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end else begin
                        load      <= 1'b0;
                        req_ready <= '0;
                    end
                end
                LOAD: begin
                    load      <= 1'b0;
                    req_ready <= '0;
                    hold_cnt  <= CW'(HOLD_CYCLES - 1);
                    state     <= HOLD;
                end
                HOLD: begin
                    // Register output stage settles while load stays low.
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    load      <= 1'b0;
                    req_ready <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipo_rr_load_sequencer.sv
// Scoreboard bench: a driver predicts grants from round-robin rules and timing
// arithmetic; a monitor compares DUT outputs and a downstream register each cycle.
module tb_pipo_rr_load_sequencer;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int H  = 2;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            load;
    logic [DW-1:0]   parallel_in;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            done;
    logic [DW-1:0]   reg_q;

    always #5 clk = ~clk;

    pipo_rr_load_sequencer #(.DATA_WIDTH(DW), .NUM_REQ(N), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .load(load), .parallel_in(parallel_in), .grant_id(grant_id),
        .busy(busy), .done(done)
    );

    // Downstream PIPO register driven by the sequencer.
    always @(posedge clk or posedge reset) begin
        if (reset) reg_q <= '0;
        else if (load) reg_q <= parallel_in;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            sel;
        logic [DW-1:0] data;
    } exp_t;

    exp_t grant_q[$];
    exp_t done_q[$];

    int checks = 0;
    int errors = 0;

    int            last = N - 1;
    int            next_free = 0;
    logic [N-1:0]  pend = '0;
    logic [N-1:0]  allow = '0;
    logic [DW-1:0] words [N];
    int            rate = 0;
    int            en_mode = 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus plus prediction for the upcoming clock edge.
    task automatic step();
        int  sel;
        bit  fnd;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) pend[i] = 1'b0;
            if (!pend[i] && allow[i] && $urandom_range(99) < rate) begin
                pend[i]  = 1'b1;
                words[i] = DW'($urandom);
            end
        end
        case (en_mode)
            0:       enable = 1'b0;
            1:       enable = 1'b1;
            default: enable = ($urandom_range(9) != 0);
        endcase
        req_valid = pend;
        for (int i = 0; i < N; i++)
            req_data[i*DW +: DW] = pend[i] ? words[i] : DW'($urandom);
        if (enable && (pend != '0) && (cyc + 1 >= next_free)) begin
            fnd = 0;
            sel = 0;
            for (int k = 1; k <= N; k++) begin
                if (!fnd && pend[(last + k) % N]) begin
                    fnd = 1;
                    sel = (last + k) % N;
                end
            end
            grant_q.push_back('{cyc + 1, sel, words[sel]});
            done_q.push_back('{cyc + 2 + H, sel, words[sel]});
            last      = sel;
            next_free = cyc + 1 + H + 2;
        end
    endtask

    task automatic drain();
        int i;
        allow = '0;
        i = 0;
        while (i < 80 && (pend != '0 || busy || grant_q.size() != 0 || done_q.size() != 0)) begin
            step();
            i++;
        end
        chk("drain_timeout", (i < 80) ? 1 : 0, 1);
    endtask

    // Monitor
    int busy_from = -100;
    always @(negedge clk) begin
        exp_t g;
        exp_t d;
        if (reset) begin
            grant_q.delete();
            done_q.delete();
            busy_from = -100;
        end else begin
            if (grant_q.size() != 0 && grant_q[0].cyc == cyc) begin
                g = grant_q.pop_front();
                chk("req_ready", longint'(req_ready), longint'(1) << g.sel);
                chk("grant_id", longint'(grant_id), g.sel);
                chk("parallel_in", longint'(parallel_in), longint'(g.data));
                chk("load", longint'(load), 1);
                busy_from = cyc;
            end else begin
                chk("idle_req_ready", longint'(req_ready), 0);
                chk("idle_load", longint'(load), 0);
            end
            chk("busy", longint'(busy), (cyc >= busy_from && cyc <= busy_from + H) ? 1 : 0);
            if (done_q.size() != 0 && done_q[0].cyc == cyc) begin
                d = done_q.pop_front();
                chk("done", longint'(done), 1);
                chk("reg_out_at_done", longint'(reg_q), longint'(d.data));
            end else begin
                chk("done_idle", longint'(done), 0);
            end
        end
    end

    task automatic model_reset();
        last      = N - 1;
        next_free = 0;
        pend      = '0;
        allow     = '0;
        req_valid = '0;
    endtask

    initial begin
        int k;
        #3;
        chk("rst_load", longint'(load), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_req_ready", longint'(req_ready), 0);
        chk("rst_grant_id", longint'(grant_id), 0);
        chk("rst_parallel_in", longint'(parallel_in), 0);
        @(negedge clk);
        reset = 1'b0;

        // Single request from requester 2
        en_mode = 1;
        words[2] = 8'hA5;
        pend = 4'b0100;
        drain();
        chk("single_grant_id", longint'(grant_id), 2);
        chk("single_parallel_in", longint'(parallel_in), 8'hA5);
        chk("single_reg_out", longint'(reg_q), 8'hA5);

        // Round-robin skip: grant 1, then {0,1} -> 0 then 1
        words[1] = 8'h31; pend = 4'b0010; drain();
        chk("rr_first", longint'(grant_id), 1);
        words[0] = 8'h40; words[1] = 8'h41; pend = 4'b0011;
        step(); step(); step();
        chk("rr_skip_to_0", longint'(grant_id), 0);
        drain();
        chk("rr_then_1", longint'(grant_id), 1);

        // All requesters continuously valid
        allow = '1; rate = 100;
        repeat (40) step();
        drain();

        // Disabled with everyone requesting
        en_mode = 0;
        for (int i = 0; i < N; i++) words[i] = DW'(8'h10 + i);
        pend = '1;
        repeat (20) step();
        chk("disabled_no_load", longint'(load), 0);
        en_mode = 1;
        drain();

        // Random traffic with enable toggling
        en_mode = 2; allow = '1; rate = 30;
        repeat (1500) step();
        en_mode = 1;
        drain();

        // Reset in the middle of HOLD
        allow = '1; rate = 100;
        k = 0;
        step();
        while (k < 20 && !(busy && !load)) begin
            step();
            k++;
        end
        chk("reach_hold", (k < 20) ? 1 : 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_load", longint'(load), 0);
        chk("async_rst_busy", longint'(busy), 0);
        chk("async_rst_done", longint'(done), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        words[3] = 8'h3C; pend = 4'b1000;
        drain();
        chk("after_rst_grant3", longint'(grant_id), 3);

        // Pointer resets too: all valid -> requester 0 first
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) words[i] = DW'(8'h50 + i);
        pend = '1;
        k = 0;
        while (k < 10 && !load) begin
            step();
            k++;
        end
        chk("first_after_rst", longint'(grant_id), 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
